// File: rtl/stream_upsizer_pkg.sv
// Shared definitions for the stream width converters (upsizer/downsizer).
package stream_upsizer_pkg;

  // Packing FSM states; the downsizer reuses the same encoding.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } pack_state_e;

  // Beat counter width; a RATIO of 2 still needs one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready holding register: loads when empty or while the current word drains.
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  // Load a new word when the slot is free; otherwise drop valid once drained.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO DW-bit beats (or fewer, closed by in_last_i) into one wide word.
//
//   state    | meaning
//   ST_ACCUM | accepting beats into the accumulator
//   ST_HOLD  | accumulator holds a completed word, output register busy
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DW-1:0]       in_data_i,
  input  logic                in_last_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DW*RATIO-1:0] out_data_o,
  output logic [RATIO-1:0]    out_keep_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int LANE_W = DW;
  localparam int CNT_W  = cnt_width(RATIO);
  localparam int WORD_W = DW * RATIO;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  pack_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   acc_data_q;
  logic [RATIO-1:0]    acc_keep_q;
  logic                ready_q;

  logic [WORD_W-1:0]   merged_data;
  logic [RATIO-1:0]    merged_keep;
  logic                beat_fire;
  logic                word_done;
  logic                load_valid;
  logic [RATIO+WORD_W-1:0] load_word;
  logic [RATIO+WORD_W-1:0] out_word;
  logic                slot_free;

  // in_ready_o is a flop so it never follows in_valid_i or out_ready_i.
  assign in_ready_o = ready_q;
  assign beat_fire  = in_valid_i && ready_q;
  assign word_done  = beat_fire && (in_last_i || (cnt_q == LAST_CNT));

  // Accumulator contents with the current beat dropped into lane cnt_q.
  always_comb begin
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    merged_data[cnt_q*LANE_W +: LANE_W] = in_data_i;
    merged_keep[cnt_q] = 1'b1;
  end

  // HOLD offers the parked word; ACCUM offers the word completed by this beat.
  always_comb begin
    load_valid = 1'b0;
    load_word  = {merged_keep, merged_data};
    if (state_q == ST_HOLD) begin
      load_valid = 1'b1;
      load_word  = {acc_keep_q, acc_data_q};
    end else if (word_done) begin
      load_valid = 1'b1;
    end
  end

  stream_out_reg #(
    .W (RATIO + WORD_W)
  ) u_out_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_data_i   (load_word),
    .in_valid_i  (load_valid),
    .in_ready_o  (slot_free),
    .out_data_o  (out_word),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  assign out_data_o = out_word[WORD_W-1:0];
  assign out_keep_o = out_word[WORD_W +: RATIO];

  // Packing FSM: fill lanes, hand completed words to the output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          ready_q <= 1'b1;
          if (beat_fire) begin
            if (word_done) begin
              cnt_q <= '0;
              if (slot_free) begin
                acc_data_q <= '0;
                acc_keep_q <= '0;
              end else begin
                acc_data_q <= merged_data;
                acc_keep_q <= merged_keep;
                state_q    <= ST_HOLD;
                ready_q    <= 1'b0;
              end
            end else begin
              acc_data_q <= merged_data;
              acc_keep_q <= merged_keep;
              cnt_q      <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            cnt_q      <= '0;
            state_q    <= ST_ACCUM;
            ready_q    <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer (RATIO=4 and RATIO=3 instances).
module tb_stream_upsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic [7:0]  in_data;
  logic        in_last, in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid, out_ready;

  logic [7:0]  in_data3;
  logic        in_last3, in_valid3, in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_keep3;
  logic        out_valid3, out_ready3;

  stream_upsizer #(.DW(8), .RATIO(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_keep_o(out_keep), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  stream_upsizer #(.DW(8), .RATIO(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_data_i(in_data3), .in_last_i(in_last3), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .out_data_o(out_data3), .out_keep_o(out_keep3), .out_valid_o(out_valid3), .out_ready_i(out_ready3)
  );

  typedef struct { logic [31:0] d; logic [3:0] k; } exp4_t;
  typedef struct { logic [23:0] d; logic [2:0] k; } exp3_t;
  exp4_t q0[$];
  exp3_t q3[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int words0    = 0;
  int words3    = 0;
  int rdy_mode  = 0;   // 0: sink ready, 1: sink stalled, 2: toggle every cycle

  logic [31:0] m_data;  logic [3:0] m_keep;  int m_cnt;
  logic [23:0] m3_data; logic [2:0] m3_keep; int m3_cnt;

  logic        stall_prev;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;

  // Sink ready pattern for the RATIO=4 instance.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ~out_ready;
    endcase
  end

  // Output monitor for RATIO=4: scoreboard pop plus hold-stability check.
  always @(negedge clk) begin
    if (rst_ni !== 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_keep !== prev_k)
          $display("FAIL hold_stable: got v=%b d=%h k=%b want v=1 d=%h k=%b",
                   out_valid, out_data, out_keep, prev_d, prev_k);
        else pass_cnt++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp4_t e;
        total_cnt++;
        words0++;
        if (q0.size() == 0) begin
          $display("FAIL word4_unexpected: got d=%h k=%b, scoreboard empty", out_data, out_keep);
        end else begin
          e = q0.pop_front();
          if (out_data !== e.d || out_keep !== e.k)
            $display("FAIL word4: got d=%h k=%b want d=%h k=%b", out_data, out_keep, e.d, e.k);
          else pass_cnt++;
        end
      end
      stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_d = out_data;
      prev_k = out_keep;
    end
  end

  // Output monitor for RATIO=3.
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
      exp3_t e;
      total_cnt++;
      words3++;
      if (q3.size() == 0) begin
        $display("FAIL word3_unexpected: got d=%h k=%b, scoreboard empty", out_data3, out_keep3);
      end else begin
        e = q3.pop_front();
        if (out_data3 !== e.d || out_keep3 !== e.k)
          $display("FAIL word3: got d=%h k=%b want d=%h k=%b", out_data3, out_keep3, e.d, e.k);
        else pass_cnt++;
      end
    end
  end

  task automatic model_clear();
    m_data = '0;  m_keep = '0;  m_cnt = 0;
    m3_data = '0; m3_keep = '0; m3_cnt = 0;
  endtask

  // Drive one beat, wait for acceptance, update the packing model.
  task automatic send_beat(input int sel, input logic [7:0] d, input logic last, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    if (sel == 0) begin in_data = d; in_last = last; in_valid = 1'b1; end
    else          begin in_data3 = d; in_last3 = last; in_valid3 = 1'b1; end
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = (sel == 0) ? (in_ready === 1'b1) : (in_ready3 === 1'b1);
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      total_cnt++;
      $display("FAIL beat_accept: got no acceptance in %0d cycles, want acceptance (beat %h)", waits, d);
    end else if (sel == 0) begin
      m_data[m_cnt*8 +: 8] = d;
      m_keep[m_cnt] = 1'b1;
      if (last || m_cnt == 3) begin
        q0.push_back('{d: m_data, k: m_keep});
        m_data = '0; m_keep = '0; m_cnt = 0;
      end else m_cnt++;
    end else begin
      m3_data[m3_cnt*8 +: 8] = d;
      m3_keep[m3_cnt] = 1'b1;
      if (last || m3_cnt == 2) begin
        q3.push_back('{d: m3_data, k: m3_keep});
        m3_data = '0; m3_keep = '0; m3_cnt = 0;
      end else m3_cnt++;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;  in_last = 1'b0;
    in_valid3 = 1'b0; in_last3 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (q0.size() != 0 || q3.size() != 0)
      $display("FAIL drain: got %0d/%0d words pending, want 0/0", q0.size(), q3.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    in_data = '0; in_data3 = '0;
    out_ready3 = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0 || in_ready !== 1'b0)
      $display("FAIL reset_state: got v=%b d=%h k=%b rdy=%b want 0/0/0/0", out_valid, out_data, out_keep, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b0)
      $display("FAIL reset_state3: got v=%b rdy=%b want 0/0", out_valid3, in_ready3);
    else pass_cnt++;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_word();
    int w, wsum;
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    rdy_mode = 0;
    out_ready = 1'b1;
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(0, beats[i], 1'b0, w);
      wsum += w;
    end
    total_cnt++;
    if (wsum != 0) $display("FAIL full_rate: got %0d stall cycles want 0", wsum);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_keep !== 4'b1111)
      $display("FAIL full_word_latency: got v=%b d=%h k=%b want v=1 d=44332211 k=1111", out_valid, out_data, out_keep);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_partial();
    int w;
    send_beat(0, 8'hAA, 1'b0, w);
    send_beat(0, 8'hBB, 1'b1, w);
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'b0011)
      $display("FAIL partial_word: got v=%b d=%h k=%b want v=1 d=0000bbaa k=0011", out_valid, out_data, out_keep);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) send_beat(0, 8'(i), 1'b0, w);
    total_cnt++;
    if (out_data !== 32'h04030201 || out_keep !== 4'b1111)
      $display("FAIL after_partial: got d=%h k=%b want d=04030201 k=1111", out_data, out_keep);
    else pass_cnt++;
    idle();
    wait_drain();
  endtask

  task automatic test_stall();
    int w, start;
    start = words0;
    rdy_mode = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) send_beat(0, 8'(i), 1'b0, w);
    idle();
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h04030201)
      $display("FAIL stall_hold: got rdy=%b v=%b d=%h want rdy=0 v=1 d=04030201", in_ready, out_valid, out_data);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || out_data !== 32'h04030201)
      $display("FAIL stall_persist: got rdy=%b d=%h want rdy=0 d=04030201", in_ready, out_data);
    else pass_cnt++;
    rdy_mode = 0;
    wait_drain();
    total_cnt++;
    if (words0 - start != 2) $display("FAIL stall_words: got %0d want 2", words0 - start);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_toggle();
    int w, start;
    start = words0;
    rdy_mode = 2;
    for (int i = 0; i < 64; i++) send_beat(0, 8'(i), 1'b0, w);
    idle();
    wait_drain();
    rdy_mode = 0;
    total_cnt++;
    if (words0 - start != 16) $display("FAIL toggle_words: got %0d want 16", words0 - start);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    rdy_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_beat(0, 8'hC1 + 8'(i), 1'b0, w);
    idle();
    rst_ni = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0 || in_ready !== 1'b0)
      $display("FAIL reset_mid: got v=%b d=%h k=%b rdy=%b want 0/0/0/0", out_valid, out_data, out_keep, in_ready);
    else pass_cnt++;
    q0.delete();
    q3.delete();
    model_clear();
    rst_ni = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(0, 8'h55 + 8'(i), 1'b0, w);
    idle();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h58575655 || out_keep !== 4'b1111)
      $display("FAIL after_reset_word: got v=%b d=%h k=%b want v=1 d=58575655 k=1111", out_valid, out_data, out_keep);
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_ratio3_last();
    int w, start;
    logic [7:0] beats [3];
    beats = '{8'h10, 8'h20, 8'h30};
    start = words3;
    for (int i = 0; i < 3; i++) begin
      send_beat(1, beats[i], 1'b1, w);
      total_cnt++;
      if (w != 0 || out_valid3 !== 1'b1 || out_data3 !== {16'h0, beats[i]} || out_keep3 !== 3'b001)
        $display("FAIL ratio3_single: got stall=%0d v=%b d=%h k=%b want stall=0 v=1 d=%h k=001",
                 w, out_valid3, out_data3, out_keep3, {16'h0, beats[i]});
      else pass_cnt++;
    end
    idle();
    wait_drain();
    total_cnt++;
    if (words3 - start != 3) $display("FAIL ratio3_words: got %0d want 3", words3 - start);
    else pass_cnt++;
  endtask

  initial begin
    out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_partial();
    test_stall();
    test_back_to_back_toggle();
    test_reset_mid();
    test_ratio3_last();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
